// File: rtl/odd_parity_serial_checker.sv
// Serial odd-parity frame checker: deserialises MSB-first frames, flags parity errors,
// presents words over valid/ready and keeps a saturating error count. Option: ODD_PARITY_CHK_DROP_EN.
module odd_parity_serial_checker #(
  parameter int input_width = 3,
  parameter int cnt_width   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ser_in,
  input  logic                   ser_valid,
  output logic                   ser_ready,
  output logic [input_width-1:0] out_data,
  output logic                   out_err,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   err_clr,
  output logic [cnt_width-1:0]   err_count
);

  localparam int frame_width   = input_width + 1;
  localparam int bit_cnt_width = $clog2(input_width + 1);
  localparam logic [bit_cnt_width-1:0] last_idx = bit_cnt_width'(input_width);

  typedef enum logic {
    SHIFT = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                   state, state_next;
  logic [bit_cnt_width-1:0] bit_cnt, bit_cnt_next;
  logic [frame_width-1:0]   frame, frame_shifted;
  logic                     accept, last_bit, frame_err, count_inc, load_word;

  assign accept        = ser_valid && ser_ready;
  assign last_bit      = (bit_cnt == last_idx);
  assign frame_shifted = {frame[frame_width-2:0], ser_in};
  // Even number of ones across data and parity bit means the frame is corrupt.
  assign frame_err     = ~^frame_shifted;
  assign count_inc     = accept && last_bit && frame_err;

  // Handshake flags decode state only, so out_ready never reaches ser_ready combinationally.
  assign ser_ready = (state == SHIFT);
  assign out_valid = (state == HOLD);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    load_word    = 1'b0;
    case (state)
      SHIFT: begin
        if (accept) begin
          if (last_bit) begin
            bit_cnt_next = '0;
`ifdef ODD_PARITY_CHK_DROP_EN
            if (!frame_err) begin
              state_next = HOLD;
              load_word  = 1'b1;
            end
`else
            state_next = HOLD;
            load_word  = 1'b1;
`endif
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next   = SHIFT;
          bit_cnt_next = '0;
        end
      end
      default: begin
        state_next   = SHIFT;
        bit_cnt_next = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SHIFT;
      bit_cnt  <= '0;
      frame    <= '0;
      out_data <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      if (accept) frame <= frame_shifted;
      if (load_word) out_data <= frame_shifted[frame_width-1:1];
    end
  end

`ifdef ODD_PARITY_CHK_DROP_EN
  assign out_err = 1'b0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_err <= 1'b0;
    else if (load_word) out_err <= frame_err;
  end
`endif

  // A clear coinciding with an error frame leaves exactly that one error counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= count_inc ? cnt_width'(1) : '0;
    end else if (count_inc && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_odd_parity_serial_checker.sv
// Directed bench for odd_parity_serial_checker (input_width=3, cnt_width=2); honours ODD_PARITY_CHK_DROP_EN.
module tb_odd_parity_serial_checker;

`ifdef ODD_PARITY_CHK_DROP_EN
  localparam bit drop_en = 1'b1;
`else
  localparam bit drop_en = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ser_in;
  logic       ser_valid;
  logic       ser_ready;
  logic [2:0] out_data;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;
  logic       err_clr;
  logic [1:0] err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  odd_parity_serial_checker #(
    .input_width(3),
    .cnt_width  (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ser_in   (ser_in),
    .ser_valid(ser_valid),
    .ser_ready(ser_ready),
    .out_data (out_data),
    .out_err  (out_err),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err_clr  (err_clr),
    .err_count(err_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame MSB first on consecutive cycles; returns at posedge+1 after the parity bit.
  task automatic send_frame(input logic [3:0] f, input logic clr_last);
    for (int i = 3; i >= 0; i--) begin
      ser_in    = f[i];
      ser_valid = 1'b1;
      err_clr   = clr_last && (i == 0);
      @(posedge clk); #1;
    end
    ser_valid = 1'b0;
    err_clr   = 1'b0;
  endtask

  // Lets a presented word transfer (out_ready high); dropped error frames need no hold cycle.
  task automatic drain(input logic bad);
    if (!(drop_en && bad)) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  logic [6:0] gap_valid = 7'b1001011;
  logic [3:0] gap_bits  = 4'b0001;

  initial begin
    rst_n = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_ser_ready", 32'(ser_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_err_count", 32'(err_count), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Good frame 1,0,1,1
    send_frame(4'b1011, 1'b0);
    check("good_valid", 32'(out_valid), 1);
    check("good_data", 32'(out_data), 5);
    check("good_err", 32'(out_err), 0);
    check("good_ser_ready", 32'(ser_ready), 0);
    check("good_cnt", 32'(err_count), 0);
    drain(1'b0);
    check("good_valid_1cyc", 32'(out_valid), 0);
    check("good_ready_back", 32'(ser_ready), 1);

    // Bad frame 1,0,1,0
    send_frame(4'b1010, 1'b0);
    check("bad_cnt", 32'(err_count), 1);
    if (drop_en) begin
      check("bad_drop_valid", 32'(out_valid), 0);
      check("bad_drop_err", 32'(out_err), 0);
      check("bad_drop_ready", 32'(ser_ready), 1);
    end else begin
      check("bad_valid", 32'(out_valid), 1);
      check("bad_data", 32'(out_data), 5);
      check("bad_err", 32'(out_err), 1);
    end
    drain(1'b1);

    // Backpressure: frame 0,1,1,1 held for 5 cycles while upstream offers a bit
    out_ready = 1'b0;
    send_frame(4'b0111, 1'b0);
    ser_in = 1'b1; ser_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(out_valid), 1);
      check("bp_data", 32'(out_data), 3);
      check("bp_ser_ready", 32'(ser_ready), 0);
      @(posedge clk); #1;
    end
    ser_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(out_valid), 0);
    check("bp_release_ready", 32'(ser_ready), 1);
    // A stray consumed bit would misalign this frame
    send_frame(4'b0100, 1'b0);
    check("bp_next_data", 32'(out_data), 2);
    check("bp_next_err", 32'(out_err), 0);
    drain(1'b0);

    // Reset mid-frame
    ser_in = 1'b1; ser_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ser_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_ready", 32'(ser_ready), 1);
    check("midrst_data", 32'(out_data), 0);
    check("midrst_cnt", 32'(err_count), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_frame(4'b1101, 1'b0);
    check("fresh_data", 32'(out_data), 6);
    check("fresh_err", 32'(out_err), 0);
    check("fresh_valid", 32'(out_valid), 1);

    // Reset while holding a word
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("holdrst_valid", 32'(out_valid), 0);
    check("holdrst_data", 32'(out_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Gaps: valid 1,0,0,1,0,1,1 carrying 0,0,0,1; idle cycles drive a misleading 1
    begin
      int k;
      k = 0;
      for (int i = 0; i < 7; i++) begin
        ser_valid = gap_valid[6-i];
        ser_in    = gap_valid[6-i] ? gap_bits[3-k] : 1'b1;
        if (gap_valid[6-i]) k++;
        if (i == 6) check("gap_not_early", 32'(out_valid), 0);
        @(posedge clk); #1;
      end
      ser_valid = 1'b0;
    end
    check("gap_valid", 32'(out_valid), 1);
    check("gap_data", 32'(out_data), 0);
    check("gap_err", 32'(out_err), 0);
    drain(1'b0);

    // Saturating counter (cnt_width=2)
    send_frame(4'b1010, 1'b0); check("sat_cnt1", 32'(err_count), 1); drain(1'b1);
    send_frame(4'b1010, 1'b0); check("sat_cnt2", 32'(err_count), 2); drain(1'b1);
    send_frame(4'b1010, 1'b0); check("sat_cnt3", 32'(err_count), 3); drain(1'b1);
    send_frame(4'b1010, 1'b0); check("sat_cnt4", 32'(err_count), 3); drain(1'b1);
    send_frame(4'b1010, 1'b1); check("clr_and_inc", 32'(err_count), 1); drain(1'b1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("clr_alone", 32'(err_count), 0);
    send_frame(4'b1011, 1'b0);
    check("good_no_inc", 32'(err_count), 0);
    drain(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
